// File: rtl/mem_bus_ctrl.sv
// Memory-stage bus master: turns a load/store flag into one bus transaction and stalls the pipe until it finishes.
// Latency: flag cycle + at least one REQ cycle. Aborts after TIMEOUT REQ cycles without ack; DONE waits out stall_hold.
module mem_bus_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read_flag_in,
  input  logic        mem_write_flag_in,
  input  logic        mem_sign_flag_in,
  input  logic [3:0]  mem_sel_in,
  input  logic [31:0] mem_write_data_in,
  input  logic [31:0] result_in,
  input  logic        reg_write_en_in,
  input  logic [4:0]  reg_write_addr_in,
  input  logic [31:0] current_pc_addr_in,
  input  logic        stall_hold,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic [31:0] ram_read_data_out,
  output logic        mem_read_flag_out,
  output logic        mem_write_flag_out,
  output logic        mem_sign_flag_out,
  output logic [3:0]  mem_sel_out,
  output logic [31:0] result_out,
  output logic        reg_write_en_out,
  output logic [4:0]  reg_write_addr_out,
  output logic [31:0] current_pc_addr_out,
  output logic        stall_request,
  output logic        bus_error
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  // Timeout fires in the REQ cycle whose missing ack would bring the count to TIMEOUT.
  localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  wait_cnt_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  be_q;
  logic        we_q;
  logic        err_q;
  logic        mem_access;
  logic        timeout_hit;

  assign mem_access  = mem_read_flag_in | mem_write_flag_in;
  assign timeout_hit = (state_q == REQ) && !bus_ack && (wait_cnt_q == WAIT_LIMIT);

  // Read+write together is treated as a store, so the read flag is masked downstream.
  assign mem_read_flag_out   = mem_read_flag_in & ~mem_write_flag_in;
  assign mem_write_flag_out  = mem_write_flag_in;
  assign mem_sign_flag_out   = mem_sign_flag_in;
  assign mem_sel_out         = mem_sel_in;
  assign result_out          = result_in;
  assign reg_write_en_out    = reg_write_en_in;
  assign reg_write_addr_out  = reg_write_addr_in;
  assign current_pc_addr_out = current_pc_addr_in;

  assign stall_request     = ((state_q == IDLE) && mem_access) || (state_q == REQ);
  assign bus_req           = (state_q == REQ);
  assign bus_we            = we_q;
  assign bus_addr          = addr_q;
  assign bus_be            = be_q;
  assign bus_wdata         = wdata_q;
  assign ram_read_data_out = rdata_q;
  assign bus_error         = err_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mem_access) state_d = REQ;
      REQ:     if (bus_ack || timeout_hit) state_d = DONE;
      DONE:    if (!stall_hold) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      wait_cnt_q <= 8'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      be_q       <= 4'd0;
      we_q       <= 1'b0;
      rdata_q    <= 32'd0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (mem_access) begin
            addr_q     <= {result_in[31:2], 2'b00};
            be_q       <= mem_sel_in;
            wdata_q    <= mem_write_data_in;
            we_q       <= mem_write_flag_in;
            wait_cnt_q <= 8'd0;
          end
        end
        REQ: begin
          if (bus_ack) begin
            rdata_q <= we_q ? 32'd0 : bus_rdata;
          end else if (timeout_hit) begin
            rdata_q <= 32'd0;
            err_q   <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Randomized scoreboard bench for mem_bus_ctrl: the driver queues the expected outcome of each access, a negedge monitor checks the bus and results.
module tb_mem_bus_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd, wr, sgn;
  logic [3:0]  sel;
  logic [31:0] wdat, res;
  logic        rwe;
  logic [4:0]  rwa;
  logic [31:0] pc;
  logic        stall_hold;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic [31:0] ram_read_data_out;
  logic        rd_o, wr_o, sgn_o;
  logic [3:0]  sel_o;
  logic [31:0] res_o;
  logic        rwe_o;
  logic [4:0]  rwa_o;
  logic [31:0] pc_o;
  logic        stall_request, bus_error;

  mem_bus_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .mem_read_flag_in(rd), .mem_write_flag_in(wr), .mem_sign_flag_in(sgn),
    .mem_sel_in(sel), .mem_write_data_in(wdat), .result_in(res),
    .reg_write_en_in(rwe), .reg_write_addr_in(rwa), .current_pc_addr_in(pc),
    .stall_hold(stall_hold),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .ram_read_data_out(ram_read_data_out),
    .mem_read_flag_out(rd_o), .mem_write_flag_out(wr_o), .mem_sign_flag_out(sgn_o),
    .mem_sel_out(sel_o), .result_out(res_o), .reg_write_en_out(rwe_o),
    .reg_write_addr_out(rwa_o), .current_pc_addr_out(pc_o),
    .stall_request(stall_request), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          cycles;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   issued   = 0;
  int   txn_seen = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor / scoreboard
  exp_t        cur;
  logic        have_cur = 1'b0;
  logic        prev_req = 1'b0;
  logic        done_now;
  int          req_cnt  = 0;
  logic [31:0] held_exp = 32'd0;

  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_bus_req", bus_req, 0);
      chk("rst_bus_error", bus_error, 0);
      chk("rst_rdata", ram_read_data_out, 0);
      chk("rst_stall", stall_request, rd | wr);
      exp_q.delete();
      have_cur = 1'b0;
      prev_req = 1'b0;
      held_exp = 32'd0;
    end else begin
      chk("passthru", {wr_o, sgn_o, sel_o, res_o, rwe_o, rwa_o, pc_o},
          {wr, sgn, sel, res, rwe, rwa, pc});
      chk("rd_flag_out", rd_o, rd & ~wr);
      if (bus_req) begin
        if (!prev_req) begin
          txn_seen++;
          req_cnt = 0;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_req actual=1 required=0 at %0t", $time);
            have_cur = 1'b0;
          end else begin
            cur      = exp_q[0];
            have_cur = 1'b1;
          end
        end
        req_cnt++;
        if (have_cur)
          chk("bus_fields", {bus_we, bus_be, bus_addr, bus_wdata},
              {cur.we, cur.be, cur.addr, cur.wdata});
        chk("req_stall", stall_request, 1);
        chk("req_bus_error", bus_error, 0);
      end else begin
        done_now = prev_req && have_cur;
        if (done_now) begin
          chk("req_cycles", req_cnt, cur.cycles);
          chk("done_stall", stall_request, 0);
          held_exp = cur.rdata;
          void'(exp_q.pop_front());
          have_cur = 1'b0;
        end
        chk("rdata_out", ram_read_data_out, held_exp);
        chk("bus_error", bus_error, done_now && cur.err);
      end
      prev_req = bus_req;
    end
  end

  // Driver: starts at posedge+1 with the DUT idle, leaves it idle at posedge+1.
  task automatic do_txn(input logic r, input logic w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] wd, input logic [31:0] rdat, input int d, input int hold);
    exp_t e;
    e.addr  = {a[31:2], 2'b00};
    e.we    = w;
    e.be    = s;
    e.wdata = wd;
    if (d < TO) begin
      e.cycles = d + 1;
      e.err    = 1'b0;
      e.rdata  = w ? 32'd0 : rdat;
    end else begin
      e.cycles = TO;
      e.err    = 1'b1;
      e.rdata  = 32'd0;
    end
    rd = r; wr = w; sel = s; res = a; wdat = wd;
    sgn = 1'($urandom); rwe = 1'($urandom); rwa = 5'($urandom); pc = $urandom;
    bus_ack = 1'b0;
    exp_q.push_back(e);
    issued++;
    #1;
    chk("idle_flag_stall", stall_request, 1);
    chk("idle_bus_req", bus_req, 0);
    @(posedge clk); #1;
    for (int k = 0; k < e.cycles; k++) begin
      bus_ack   = (k == d);
      bus_rdata = (k == d) ? rdat : $urandom;
      @(posedge clk); #1;
    end
    stall_hold = (hold > 0);
    for (int i = 0; i <= hold; i++) begin
      stall_hold = (i < hold);
      bus_ack    = 1'($urandom);
      bus_rdata  = $urandom;
      #1;
      chk("done_no_req", {bus_req, stall_request}, 0);
      @(posedge clk); #1;
    end
    bus_ack = 1'b0;
    stall_hold = 1'b0;
  endtask

  task automatic idle_gap(input int n);
    rd = 1'b0; wr = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus_ack   = 1'($urandom);
      bus_rdata = $urandom;
      @(posedge clk); #1;
    end
    bus_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b0; rd = 0; wr = 0; sgn = 0; sel = 0; wdat = 0; res = 0;
    rwe = 0; rwa = 0; pc = 0; stall_hold = 0; bus_ack = 0; bus_rdata = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    do_txn(1, 0, 32'h1000_0006, 4'b1111, 32'h0, 32'hDEAD_BEEF, 0, 0);
    idle_gap(1);
    do_txn(0, 1, 32'h2000_0013, 4'b0011, 32'h1234_5678, 32'hAAAA_5555, 2, 0);
    idle_gap(1);
    do_txn(1, 0, 32'h3000_0000, 4'b1111, 32'h0, 32'h0BAD_0BAD, 99, 0);
    idle_gap(1);
    do_txn(1, 0, 32'h4000_0101, 4'b1100, 32'h0, 32'hCAFE_F00D, 0, 3);
    do_txn(1, 0, 32'h5000_0002, 4'b0001, 32'h0, 32'h1111_2222, 0, 0);
    do_txn(1, 0, 32'h5000_0007, 4'b0010, 32'h0, 32'h3333_4444, 0, 0);
    do_txn(1, 1, 32'h6000_000B, 4'b1111, 32'h9999_8888, 32'h7777_6666, 1, 0);
    do_txn(1, 0, 32'h7000_0004, 4'b1111, 32'h0, 32'h5A5A_A5A5, TO - 1, 0);

    for (int n = 0; n < 40; n++) begin
      int kind;
      kind = $urandom_range(0, 3);
      idle_gap($urandom_range(0, 2));
      do_txn(kind == 0 || kind == 2 || kind == 3, kind == 1 || kind == 2, $urandom,
             4'($urandom), $urandom, $urandom, $urandom_range(0, 5), $urandom_range(0, 2));
    end

    // Reset in the second REQ cycle abandons the access.
    idle_gap(1);
    rd = 1'b1; wr = 1'b0; res = 32'h8000_0000; sel = 4'hF;
    begin
      exp_t e;
      e.addr = 32'h8000_0000; e.we = 0; e.be = 4'hF; e.wdata = wdat;
      e.rdata = 0; e.err = 0; e.cycles = TO;
      exp_q.push_back(e);
      issued++;
    end
    @(posedge clk); #1;
    @(posedge clk); #2;
    chk("pre_rst_req", bus_req, 1);
    rst = 1'b0;
    #1;
    chk("async_drop_req", bus_req, 0);
    chk("async_no_err", bus_error, 0);
    @(posedge clk); #3;
    rd = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_idle", {bus_req, stall_request, bus_error}, 0);
    do_txn(1, 0, 32'h9000_0010, 4'b1111, 32'h0, 32'h0123_4567, 0, 0);
    idle_gap(3);

    chk("queue_empty", exp_q.size(), 0);
    chk("txn_count", txn_seen, issued);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
